hjbus_host: RTL and testbench

Register-bus initiator that turns a host byte stream into single register transactions on the 12-bit/32-bit `regreq`/`regack` bus used by the debug and peripheral blocks. It sits between a byte transport (UART or USB FIFO wrapper) and a register slave. It parses one command packet at a time, issues one bus access, and returns a status byte plus read data. A timeout keeps the host link alive when a slave never acknowledges.

---
 rtl/hjbus_host.sv | 130 +++++++++++++
 tb/tb_hjbus_host.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hjbus_host.sv
// Byte-stream to regreq/regack bus initiator: parses one command packet, issues one
// register access, then returns a status byte plus read data for successful reads.
module hjbus_host #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  output logic        rxready,
  output logic [7:0]  txdata,
  output logic        txvalid,
  input  logic        txready,
  output logic        regreq,
  output logic        regwr,
  output logic [11:0] regaddr,
  output logic [31:0] regwdata,
  input  logic        regack,
  input  logic        regerr,
  input  logic [31:0] regrdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] StatOk      = 8'h00;
  localparam logic [7:0] StatSlvErr  = 8'h01;
  localparam logic [7:0] StatTimeout = 8'h02;
  localparam logic [7:0] StatBadCmd  = 8'h03;

  typedef enum logic [2:0] {
    StCmd,
    StAddr,
    StData,
    StReq,
    StWait,
    StStatus,
    StRdata
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] tmo_cnt_q;
  logic [1:0]      byte_cnt_q;
  logic [7:0]      status_q;
  logic [31:0]     rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCmd;
      tmo_cnt_q  <= '0;
      byte_cnt_q <= '0;
      status_q   <= StatOk;
      rdata_q    <= '0;
      regwr      <= 1'b0;
      regaddr    <= '0;
      regwdata   <= '0;
    end else begin
      unique case (state_q)
        StCmd: begin
          if (rxvalid) begin
            if (rxdata[6:4] != 3'b000) begin
              status_q <= StatBadCmd;
              state_q  <= StStatus;
            end else begin
              regwr         <= rxdata[7];
              regaddr[11:8] <= rxdata[3:0];
              state_q       <= StAddr;
            end
          end
        end
        StAddr: begin
          if (rxvalid) begin
            regaddr[7:0] <= rxdata;
            byte_cnt_q   <= '0;
            state_q      <= regwr ? StData : StReq;
          end
        end
        StData: begin
          if (rxvalid) begin
            regwdata[{byte_cnt_q, 3'b000} +: 8] <= rxdata;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) state_q <= StReq;
          end
        end
        StReq: begin
          tmo_cnt_q <= CntW'(TIMEOUT);
          state_q   <= StWait;
        end
        StWait: begin
          tmo_cnt_q <= tmo_cnt_q - CntW'(1);
          // An ack in the final counted cycle still takes priority over the timeout.
          if (regack) begin
            status_q <= regerr ? StatSlvErr : StatOk;
            rdata_q  <= regrdata;
            state_q  <= StStatus;
          end else if (tmo_cnt_q == CntW'(1)) begin
            status_q <= StatTimeout;
            state_q  <= StStatus;
          end
        end
        StStatus: begin
          if (txready) begin
            byte_cnt_q <= '0;
            state_q    <= (!regwr && status_q == StatOk) ? StRdata : StCmd;
          end
        end
        StRdata: begin
          if (txready) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) state_q <= StCmd;
          end
        end
        default: state_q <= StCmd;
      endcase
    end
  end

  assign regreq  = (state_q == StReq);
  assign rxready = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
  assign txvalid = (state_q == StStatus) || (state_q == StRdata);

  always_comb begin
    txdata = 8'h00;
    if (state_q == StStatus) begin
      txdata = status_q;
    end else if (state_q == StRdata) begin
      txdata = rdata_q[{byte_cnt_q, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_hjbus_host.sv
// Directed bench for hjbus_host: table of packets with hand-computed bus/response
// expectations, plus hand sequences for timeout/late-ack and reset abort.
module tb_hjbus_host;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxdata = 8'h00;
  logic        rxvalid = 1'b0;
  logic        rxready;
  logic [7:0]  txdata;
  logic        txvalid;
  logic        txready = 1'b0;
  logic        regreq;
  logic        regwr;
  logic [11:0] regaddr;
  logic [31:0] regwdata;
  logic        regack = 1'b0;
  logic        regerr = 1'b0;
  logic [31:0] regrdata = 32'h0;

  int total = 0;
  int bad = 0;

  hjbus_host #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxdata   (rxdata),
    .rxvalid  (rxvalid),
    .rxready  (rxready),
    .txdata   (txdata),
    .txvalid  (txvalid),
    .txready  (txready),
    .regreq   (regreq),
    .regwr    (regwr),
    .regaddr  (regaddr),
    .regwdata (regwdata),
    .regack   (regack),
    .regerr   (regerr),
    .regrdata (regrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] rx;     // byte i at [8*i +: 8]
    int          nrx;
    int          dly;    // ack in cycle regreq+dly; 0 = never
    logic        err;
    logic [31:0] rdata;
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [39:0] tx;     // byte i at [8*i +: 8]
    int          ntx;
    logic        toggle; // txready 1010... while collecting
    logic        badcmd;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [47:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      rxdata  = b[8*i +: 8];
      rxvalid = 1'b1;
      w = 0;
      while (!rxready && w < 50) begin
        tick();
        w++;
      end
      if (!rxready) check("rxready_timeout", 32'(rxready), 32'd1);
      tick();
    end
    rxvalid = 1'b0;
    rxdata  = 8'h00;
  endtask

  // Starts in the cycle after regreq; lat = cycles from regreq to txvalid.
  task automatic wait_tx(input int dly, input logic err, input logic [31:0] rd, output int lat);
    int k;
    lat = -1;
    k = 1;
    while (k < 200 && lat < 0) begin
      if (txvalid) begin
        lat = k;
      end else begin
        regack   = (k == dly);
        regerr   = err;
        regrdata = rd;
        tick();
        k++;
      end
    end
    regack = 1'b0;
  endtask

  task automatic collect(input logic [39:0] exp, input int n, input logic toggle);
    int i;
    int c;
    logic stalled;
    logic [7:0] held;
    i = 0;
    c = 0;
    stalled = 1'b0;
    held = 8'h00;
    while (i < n && c < 100) begin
      txready = toggle ? ~c[0] : 1'b1;
      check("txvalid_high", 32'(txvalid), 32'd1);
      if (stalled) check("txdata_stable", 32'(txdata), 32'(held));
      if (txready) begin
        check($sformatf("txbyte%0d", i), 32'(txdata), 32'(exp[8*i +: 8]));
        i++;
        stalled = 1'b0;
      end else begin
        held = txdata;
        stalled = 1'b1;
      end
      tick();
      c++;
    end
    txready = 1'b0;
    check("tx_count", 32'(i), 32'(n));
    check("txvalid_done", 32'(txvalid), 32'd0);
    check("rxready_after", 32'(rxready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send(v.rx, v.nrx);
    if (v.badcmd) begin
      check("bad_noreq", 32'(regreq), 32'd0);
      check("bad_rxready", 32'(rxready), 32'd0);
    end else begin
      check("regreq", 32'(regreq), 32'd1);
      check("regaddr", 32'(regaddr), 32'(v.addr));
      check("regwr", 32'(regwr), 32'(v.wr));
      if (v.wr) check("regwdata", regwdata, v.wdata);
      tick();
      check("regreq_pulse", 32'(regreq), 32'd0);
      wait_tx(v.dly, v.err, v.rdata, lat);
      check("latency", 32'(lat), (v.dly > 0) ? 32'(v.dly + 1) : 32'(TO + 1));
      check("regaddr_hold", 32'(regaddr), 32'(v.addr));
    end
    collect(v.tx, v.ntx, v.toggle);
  endtask

  initial begin
    int lat;
    logic seen;

    //          rx                nrx dly err rdata         addr    wr    wdata         tx                 ntx tog   bad
    vecs[0] = '{48'h0400,          2, 3,  1'b0, 32'h00000400, 12'h004, 1'b0, 32'h0,        40'h0000040000,  5, 1'b0, 1'b0};
    vecs[1] = '{48'h123456781480,  6, 1,  1'b0, 32'hFFFFFFFF, 12'h014, 1'b1, 32'h12345678, 40'h0,           1, 1'b0, 1'b0};
    vecs[2] = '{48'hFC0F,          2, 2,  1'b1, 32'hDEADBEEF, 12'hFFC, 1'b0, 32'h0,        40'h01,          1, 1'b0, 1'b0};
    vecs[3] = '{48'h2000,          2, 0,  1'b0, 32'h0,        12'h020, 1'b0, 32'h0,        40'h02,          1, 1'b0, 1'b0};
    vecs[4] = '{48'h40,            1, 0,  1'b0, 32'h0,        12'h000, 1'b0, 32'h0,        40'h03,          1, 1'b0, 1'b1};
    vecs[5] = '{48'h2301,          2, 16, 1'b0, 32'hA1B2C3D4, 12'h123, 1'b0, 32'h0,        40'hA1B2C3D400,  5, 1'b1, 1'b0};
    vecs[6] = '{48'hDEADBEEFA085,  6, 1,  1'b1, 32'h0,        12'h5A0, 1'b1, 32'hDEADBEEF, 40'h01,          1, 1'b1, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_rxready", 32'(rxready), 32'd1);
    check("rst_txvalid", 32'(txvalid), 32'd0);
    check("rst_txdata", 32'(txdata), 32'd0);
    check("rst_regreq", 32'(regreq), 32'd0);
    check("rst_regwr", 32'(regwr), 32'd0);
    check("rst_regaddr", 32'(regaddr), 32'd0);
    check("rst_regwdata", regwdata, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Timeout, then a late ack while the status byte is stalled.
    send(48'h3000, 2);
    check("to_regreq", 32'(regreq), 32'd1);
    tick();
    wait_tx(0, 1'b0, 32'h0, lat);
    check("to_latency", 32'(lat), 32'(TO + 1));
    repeat (4) tick();
    regack = 1'b1; regerr = 1'b1; regrdata = 32'hFFFFFFFF;
    tick();
    regack = 1'b0; regerr = 1'b0;
    check("late_txvalid", 32'(txvalid), 32'd1);
    check("late_txdata", 32'(txdata), 32'h02);
    collect(40'h02, 1, 1'b0);
    run_vec(vecs[5]);

    // Reset during write DATA phase aborts with no bus access or response.
    send(48'h22111480, 4);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      regack = (c == 3);
      if (regreq || txvalid) seen = 1'b1;
      tick();
    end
    regack = 1'b0;
    check("post_rst_quiet", 32'(seen), 32'd0);
    check("post_rst_regwdata", regwdata, 32'd0);
    check("post_rst_regaddr", 32'(regaddr), 32'd0);
    check("post_rst_rxready", 32'(rxready), 32'd1);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
